// File: rtl/seq_div_if.sv
// Start/result bundle for the sequential divider: operands in, quotient/remainder and status out.
interface seq_div_if #(
    parameter int N = 8,
    parameter int M = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         busy;
    logic         done;
    logic         dz;

    modport master (output start, a, b, input q, r, busy, done, dz);
    modport slave  (input start, a, b, output q, r, busy, done, dz);
endinterface

// File: rtl/seq_div.sv
// Restoring unsigned divider, one quotient bit per clock; results are held until the next done pulse.
module seq_div #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic     clk,
    input  logic     clr,
    seq_div_if.slave io
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  aq_q, aq_d;
    logic [M-1:0]  b_q, b_d;
    logic [M:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dzp_q, dzp_d;
    logic [N-1:0]  q_q, q_d;
    logic [M-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;

    // Shifted remainder never reaches 2^(M+1), so bit M+1 of the difference is the borrow.
    logic [M+1:0]  rem_sh;
    logic [M+1:0]  diff;

    always_comb begin
        state_d = state_q;
        aq_d    = aq_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dzp_d   = dzp_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        rem_sh  = {rem_q, aq_q[N-1]};
        diff    = rem_sh - {2'b00, b_q};

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    aq_d    = io.a;
                    b_d     = io.b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dzp_d   = (io.b == '0);
                    state_d = (io.b == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                rem_d = diff[M+1] ? rem_sh[M:0] : diff[M:0];
                aq_d  = {aq_q[N-2:0], ~diff[M+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dzp_q) begin
                    q_d  = '1;
                    r_d  = '0;
                    dz_d = 1'b1;
                end else begin
                    q_d  = aq_q;
                    r_d  = rem_q[M-1:0];
                    dz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            aq_q    <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dzp_q   <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aq_q    <= aq_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dzp_q   <= dzp_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign io.q    = q_q;
    assign io.r    = r_q;
    assign io.dz   = dz_q;
    assign io.done = done_q;
    assign io.busy = (state_q != IDLE);
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: hand-computed quotients, latency, back-to-back, divide-by-zero and clr abort.
module tb_seq_div;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_div_if #(.N(8), .M(4)) dif ();
    seq_div #(.N(8), .M(4)) u_dut (.clk(clk), .clr(clr), .io(dif));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"},    32'(dif.q),    32'h0);
        chk({tag, "_r"},    32'(dif.r),    32'h0);
        chk({tag, "_busy"}, 32'(dif.busy), 32'h0);
        chk({tag, "_done"}, 32'(dif.done), 32'h0);
        chk({tag, "_dz"},   32'(dif.dz),   32'h0);
    endtask

    // Accept one division, then follow it to done checking busy span, latency and results.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic edz,
                           input int lat);
        int n;
        int nbusy;
        n = 0;
        nbusy = 0;
        dif.a = a;
        dif.b = b;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        while (!dif.done && n < 30) begin
            if (dif.busy) nbusy++;
            tick();
            n++;
        end
        chk({tag, "_lat"},   32'(n),        32'(lat));
        chk({tag, "_bsy"},   32'(nbusy),    32'(lat));
        chk({tag, "_bdone"}, 32'(dif.busy), 32'h0);
        chk({tag, "_q"},     32'(dif.q),    32'(eq));
        chk({tag, "_r"},     32'(dif.r),    32'(er));
        chk({tag, "_dz"},    32'(dif.dz),   32'(edz));
        tick();
        chk({tag, "_done1"}, 32'(dif.done), 32'h0);
        chk({tag, "_hold"},  32'(dif.q),    32'(eq));
    endtask

    initial begin
        int n;
        logic exp_done;
        dif.start = 1'b0;
        dif.a = '0;
        dif.b = '0;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk_zero("rst");

        run_div("c8_7", 8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 9);
        run_div("ff_f", 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 9);
        run_div("0f_f", 8'h0F, 4'hF, 8'h01, 4'h0, 1'b0, 9);
        run_div("05_9", 8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 9);
        run_div("dz",   8'h3A, 4'h0, 8'hFF, 4'h0, 1'b1, 1);
        run_div("10_4", 8'h10, 4'h4, 8'h04, 4'h0, 1'b0, 9);

        // Start held high: accepted every 10 cycles, done on the last of each window.
        dif.a = 8'hFF;
        dif.b = 4'h1;
        dif.start = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_done = ((i % 10) == 9);
            chk("b2b_done", 32'(dif.done), 32'(exp_done));
            chk("b2b_busy", 32'(dif.busy), 32'(!exp_done));
            if (exp_done) begin
                chk("b2b_q", 32'(dif.q), 32'hFF);
                chk("b2b_r", 32'(dif.r), 32'h0);
            end
        end
        dif.start = 1'b0;
        n = 0;
        while (!dif.done && n < 30) begin
            tick();
            n++;
        end
        chk("b2b_drain", 32'(n < 30), 32'h1);
        tick();

        // Operand changes and extra starts during a run must not disturb it.
        dif.a = 8'hC8;
        dif.b = 4'h7;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        tick();
        tick();
        dif.a = 8'h55;
        dif.b = 4'h3;
        dif.start = 1'b1;
        tick();
        dif.a = 8'h12;
        dif.b = 4'hE;
        tick();
        dif.start = 1'b0;
        dif.a = 8'hFF;
        dif.b = 4'h0;
        n = 4;
        while (!dif.done && n < 30) begin
            tick();
            n++;
        end
        chk("iso_lat", 32'(n), 32'd9);
        chk("iso_q",   32'(dif.q), 32'h1C);
        chk("iso_r",   32'(dif.r), 32'h4);
        chk("iso_dz",  32'(dif.dz), 32'h0);
        tick();

        // clr four cycles into a division discards it.
        dif.a = 8'hC8;
        dif.b = 4'h7;
        dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_zero("abort");
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_nodone", 32'(dif.done), 32'h0);
        end
        run_div("post", 8'h10, 4'h4, 8'h04, 4'h0, 1'b0, 9);

        // clr and start together: nothing accepted.
        dif.a = 8'h20;
        dif.b = 4'h2;
        dif.start = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        dif.start = 1'b0;
        chk("clrstart_busy", 32'(dif.busy), 32'h0);
        tick();
        chk("clrstart_busy2", 32'(dif.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
